// File: rtl/load_store_unit.sv
// Load/store request controller for a 64-bit-wide doubleword memory.
// Checks alignment/range, sequences read, read-modify-write and write, returns extended loads.
//   state   | meaning
//   S_IDLE  | ready for a request
//   S_RD    | memory read strobe, doubleword index on the address bus
//   S_RDATA | memory data valid: extract the load field or merge the store bytes
//   S_WR    | memory write strobe, merged doubleword on the data bus
//   S_RESP  | response held until the consumer takes it
module load_store_unit #(
  parameter int MEM_DEPTH = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  input  logic [63:0] i_req_address,
  input  logic [63:0] i_req_write_data,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [63:0] o_resp_read_data,
  output logic        o_resp_error,
  output logic [63:0] o_mem_address,
  output logic [63:0] o_mem_write_data,
  output logic        o_memory_read,
  output logic        o_memory_write,
  input  logic [63:0] i_mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RDATA,
    S_WR,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_resp_data;
  logic        r_resp_error;

  logic        w_misaligned;
  logic        w_range_err;
  logic        w_err;
  logic [5:0]  w_shift;
  logic [63:0] w_lane_mask;
  logic [63:0] w_pos_mask;
  logic [63:0] w_field;
  logic [63:0] w_load_ext;
  logic [63:0] w_merged;

  always_comb begin
    w_misaligned = 1'b0;
    case (i_req_size)
      2'd0: w_misaligned = 1'b0;
      2'd1: w_misaligned = i_req_address[0];
      2'd2: w_misaligned = (i_req_address[1:0] != 2'b00);
      2'd3: w_misaligned = (i_req_address[2:0] != 3'b000);
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_range_err = ({3'b000, i_req_address[63:3]} >= 64'(MEM_DEPTH));
  assign w_err       = w_misaligned | w_range_err;

  // Lane datapath works on the captured request and the live memory read data.
  assign w_shift = {r_addr[2:0], 3'b000};

  always_comb begin
    w_lane_mask = '1;
    case (r_size)
      2'd0: w_lane_mask = 64'h0000_0000_0000_00FF;
      2'd1: w_lane_mask = 64'h0000_0000_0000_FFFF;
      2'd2: w_lane_mask = 64'h0000_0000_FFFF_FFFF;
      2'd3: w_lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      default: w_lane_mask = '1;
    endcase
  end

  assign w_pos_mask = w_lane_mask << w_shift;
  assign w_field    = (i_mem_read_data >> w_shift) & w_lane_mask;
  assign w_merged   = (i_mem_read_data & ~w_pos_mask) | ((r_wdata << w_shift) & w_pos_mask);

  always_comb begin
    w_load_ext = w_field;
    case (r_size)
      2'd0: w_load_ext = r_signed ? {{56{w_field[7]}}, w_field[7:0]} : w_field;
      2'd1: w_load_ext = r_signed ? {{48{w_field[15]}}, w_field[15:0]} : w_field;
      2'd2: w_load_ext = r_signed ? {{32{w_field[31]}}, w_field[31:0]} : w_field;
      2'd3: w_load_ext = w_field;
      default: w_load_ext = w_field;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          if (w_err) begin
            w_next = S_RESP;
          end else if (i_req_write && (i_req_size == 2'd3)) begin
            w_next = S_WR;
          end else begin
            w_next = S_RD;
          end
        end
      end
      S_RD:    w_next = S_RDATA;
      S_RDATA: w_next = r_write ? S_WR : S_RESP;
      S_WR:    w_next = S_RESP;
      S_RESP:  w_next = i_resp_ready ? S_IDLE : S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_size       <= 2'd0;
      r_signed     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_data  <= '0;
      r_resp_error <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_write      <= i_req_write;
            r_size       <= i_req_size;
            r_signed     <= i_req_signed;
            r_addr       <= i_req_address;
            r_wdata      <= i_req_write_data;
            r_resp_data  <= '0;
            r_resp_error <= w_err;
          end
        end
        S_RDATA: begin
          // Store data register is reused to hold the merged doubleword for S_WR.
          if (r_write) begin
            r_wdata <= w_merged;
          end else begin
            r_resp_data <= w_load_ext;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_req_ready      = (r_state == S_IDLE);
  assign o_resp_valid     = (r_state == S_RESP);
  assign o_resp_read_data = r_resp_data;
  assign o_resp_error     = r_resp_error;
  assign o_memory_read    = (r_state == S_RD);
  assign o_memory_write   = (r_state == S_WR);
  assign o_mem_address    = ((r_state == S_RD) || (r_state == S_RDATA) || (r_state == S_WR))
                            ? {3'b000, r_addr[63:3]} : 64'd0;
  assign o_mem_write_data = (r_state == S_WR) ? r_wdata : 64'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written corner sequences,
// and random traffic checked against a byte-array reference model.
module tb_load_store_unit;

  logic        clk;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_write;
  logic [1:0]  i_req_size;
  logic        i_req_signed;
  logic [63:0] i_req_address;
  logic [63:0] i_req_write_data;
  logic        o_resp_valid;
  logic        i_resp_ready;
  logic [63:0] o_resp_read_data;
  logic        o_resp_error;
  logic [63:0] o_mem_address;
  logic [63:0] o_mem_write_data;
  logic        o_memory_read;
  logic        o_memory_write;
  logic [63:0] mem_rdata;

  load_store_unit #(.MEM_DEPTH(64)) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .i_req_valid      (i_req_valid),
    .o_req_ready      (o_req_ready),
    .i_req_write      (i_req_write),
    .i_req_size       (i_req_size),
    .i_req_signed     (i_req_signed),
    .i_req_address    (i_req_address),
    .i_req_write_data (i_req_write_data),
    .o_resp_valid     (o_resp_valid),
    .i_resp_ready     (i_resp_ready),
    .o_resp_read_data (o_resp_read_data),
    .o_resp_error     (o_resp_error),
    .o_mem_address    (o_mem_address),
    .o_mem_write_data (o_mem_write_data),
    .o_memory_read    (o_memory_read),
    .o_memory_write   (o_memory_write),
    .i_mem_read_data  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream memory: read captured at posedge, write committed at negedge.
  logic [63:0] mem [64];
  logic        mem_clear;

  always @(posedge clk) begin
    if (o_memory_read) mem_rdata <= mem[o_mem_address[5:0]];
  end

  always @(negedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= 64'd0;
    end else if (o_memory_write) begin
      mem[o_mem_address[5:0]] <= o_mem_write_data;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: flat byte-addressed memory, plain arithmetic on the request.
  logic [7:0] ref_mem [512];

  task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [63:0] a, input logic [63:0] wd,
                       output logic [63:0] d, output logic e, output int lat);
    int nb;
    nb = 1 << sz;
    d = 64'd0;
    e = ((a % 64'(nb)) != 0) || ((a / 8) >= 64);
    if (e) begin
      lat = 1;
    end else if (w) begin
      for (int i = 0; i < nb; i++) ref_mem[int'(a[8:0]) + i] = wd[8*i +: 8];
      lat = (nb == 8) ? 2 : 4;
    end else begin
      for (int i = 0; i < nb; i++) d = d | (64'(ref_mem[int'(a[8:0]) + i]) << (8*i));
      if (sg && nb < 8 && d[8*nb-1]) d = d | (~64'd0 << (8*nb));
      lat = 3;
    end
  endtask

  // Issues one request, returns response, latency, first strobe cycles and a protocol flag.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [63:0] a, input logic [63:0] wd, input int hold,
                        output logic [63:0] data, output logic err, output int lat,
                        output int rdc, output int wrc, output logic bad);
    lat = 0; rdc = 0; wrc = 0; bad = 1'b0; data = '0; err = 1'b0;
    @(negedge clk);
    chk("req_ready_idle", 64'(o_req_ready), 64'd1);
    i_req_write = w; i_req_size = sz; i_req_signed = sg;
    i_req_address = a; i_req_write_data = wd; i_req_valid = 1'b1;
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    i_req_write = 1'($urandom); i_req_size = 2'($urandom); i_req_signed = 1'($urandom);
    i_req_address = {$urandom, $urandom}; i_req_write_data = {$urandom, $urandom};
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge clk);
      if (o_memory_read && rdc == 0) rdc = k;
      if (o_memory_write && wrc == 0) wrc = k;
      if (o_memory_read && o_memory_write) bad = 1'b1;
      if ((o_memory_read || o_memory_write) && o_mem_address != {3'b000, a[63:3]}) bad = 1'b1;
      if (o_req_ready) bad = 1'b1;
      if (o_resp_valid) lat = k;
    end
    if (lat == 0) begin
      tests++;
      fails++;
      $display("FAIL resp_timeout: got no RespValid expected within 12 cycles");
      return;
    end
    data = o_resp_read_data;
    err  = o_resp_error;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!o_resp_valid || o_resp_read_data !== data || o_resp_error !== err || o_req_ready)
        bad = 1'b1;
    end
    i_resp_ready = 1'b1;
    if (o_req_ready) bad = 1'b1;
    @(posedge clk);
    #1;
    i_resp_ready = 1'b0;
    if (o_resp_valid || !o_req_ready) bad = 1'b1;
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [63:0] a;
    logic [63:0] wd;
    logic [63:0] ed;
    logic        ee;
    int          el;
  } vec_t;

  vec_t vt [17];

  function automatic int exp_rd(input int lat);
    return (lat == 3 || lat == 4) ? 1 : 0;
  endfunction

  function automatic int exp_wr(input int lat);
    return (lat == 2) ? 1 : ((lat == 4) ? 3 : 0);
  endfunction

  initial begin
    logic [63:0] d, md;
    logic        e, me, bad;
    int          lat, mlat, rdc, wrc;
    logic        w, sg;
    logic [1:0]  sz;
    logic [63:0] a, wd;
    int          r;

    vt[0]  = '{1'b1, 2'd3, 1'b0, 64'h10,  64'h1122334455667788, 64'h0, 1'b0, 2};
    vt[1]  = '{1'b0, 2'd3, 1'b0, 64'h10,  64'h0, 64'h1122334455667788, 1'b0, 3};
    vt[2]  = '{1'b1, 2'd0, 1'b0, 64'h13,  64'h123456789ABCDEAB, 64'h0, 1'b0, 4};
    vt[3]  = '{1'b0, 2'd3, 1'b0, 64'h10,  64'h0, 64'h11223344AB667788, 1'b0, 3};
    vt[4]  = '{1'b0, 2'd0, 1'b1, 64'h13,  64'h0, 64'hFFFFFFFFFFFFFFAB, 1'b0, 3};
    vt[5]  = '{1'b0, 2'd0, 1'b0, 64'h13,  64'h0, 64'h00000000000000AB, 1'b0, 3};
    vt[6]  = '{1'b0, 2'd1, 1'b1, 64'h12,  64'h0, 64'hFFFFFFFFFFFFAB66, 1'b0, 3};
    vt[7]  = '{1'b0, 2'd2, 1'b0, 64'h06,  64'h0, 64'h0, 1'b1, 1};
    vt[8]  = '{1'b0, 2'd3, 1'b0, 64'h200, 64'h0, 64'h0, 1'b1, 1};
    vt[9]  = '{1'b1, 2'd1, 1'b0, 64'h1E,  64'hDEADBEEF, 64'h0, 1'b0, 4};
    vt[10] = '{1'b0, 2'd2, 1'b0, 64'h1C,  64'h0, 64'h00000000BEEF0000, 1'b0, 3};
    vt[11] = '{1'b0, 2'd2, 1'b1, 64'h1C,  64'h0, 64'hFFFFFFFFBEEF0000, 1'b0, 3};
    vt[12] = '{1'b1, 2'd1, 1'b0, 64'h11,  64'h5555, 64'h0, 1'b1, 1};
    vt[13] = '{1'b1, 2'd0, 1'b1, 64'h1FF, 64'h5A, 64'h0, 1'b0, 4};
    vt[14] = '{1'b0, 2'd0, 1'b1, 64'h1FF, 64'h0, 64'h000000000000005A, 1'b0, 3};
    vt[15] = '{1'b0, 2'd3, 1'b1, 64'h1F8, 64'h0, 64'h5A00000000000000, 1'b0, 3};
    vt[16] = '{1'b0, 2'd3, 1'b0, 64'h10,  64'h0, 64'h11223344AB667788, 1'b0, 3};

    for (int i = 0; i < 512; i++) ref_mem[i] = 8'd0;
    i_rst = 1'b1; mem_clear = 1'b1;
    i_req_valid = 1'b0; i_req_write = 1'b0; i_req_size = 2'd0; i_req_signed = 1'b0;
    i_req_address = '0; i_req_write_data = '0; i_resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready",  64'(o_req_ready), 64'd1);
    chk("rst_resp_valid", 64'(o_resp_valid), 64'd0);
    chk("rst_resp_error", 64'(o_resp_error), 64'd0);
    chk("rst_resp_data",  o_resp_read_data, 64'd0);
    chk("rst_mem_addr",   o_mem_address, 64'd0);
    chk("rst_mem_wdata",  o_mem_write_data, 64'd0);
    chk("rst_mem_read",   64'(o_memory_read), 64'd0);
    chk("rst_mem_write",  64'(o_memory_write), 64'd0);
    @(negedge clk);
    i_rst = 1'b0; mem_clear = 1'b0;

    for (int i = 0; i < 17; i++) begin
      do_req(vt[i].w, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd, 0, d, e, lat, rdc, wrc, bad);
      model(vt[i].w, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd, md, me, mlat);
      chk($sformatf("vec%0d_data", i), d, vt[i].ed);
      chk($sformatf("vec%0d_err", i), 64'(e), 64'(vt[i].ee));
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vt[i].el));
      chk($sformatf("vec%0d_rd_cycle", i), 64'(rdc), 64'(exp_rd(vt[i].el)));
      chk($sformatf("vec%0d_wr_cycle", i), 64'(wrc), 64'(exp_wr(vt[i].el)));
      chk($sformatf("vec%0d_protocol", i), 64'(bad), 64'd0);
    end

    // Backpressure: response held five cycles with RespReady low.
    do_req(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 5, d, e, lat, rdc, wrc, bad);
    chk("hold_data", d, 64'h11223344AB667788);
    chk("hold_lat", 64'(lat), 64'd3);
    chk("hold_protocol", 64'(bad), 64'd0);

    // Reset during WR of a byte store, before the negedge.
    do_req(1'b1, 2'd3, 1'b0, 64'h40, 64'h0123456789ABCDEF, 0, d, e, lat, rdc, wrc, bad);
    model(1'b1, 2'd3, 1'b0, 64'h40, 64'h0123456789ABCDEF, md, me, mlat);
    @(negedge clk);
    i_req_write = 1'b1; i_req_size = 2'd0; i_req_signed = 1'b0;
    i_req_address = 64'h43; i_req_write_data = 64'h77; i_req_valid = 1'b1;
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rstwr_in_wr", 64'(o_memory_write), 64'd1);
    i_rst = 1'b1;
    #1;
    chk("rstwr_mem_write", 64'(o_memory_write), 64'd0);
    chk("rstwr_req_ready", 64'(o_req_ready), 64'd1);
    chk("rstwr_resp_valid", 64'(o_resp_valid), 64'd0);
    chk("rstwr_mem_addr", o_mem_address, 64'd0);
    chk("rstwr_mem_wdata", o_mem_write_data, 64'd0);
    chk("rstwr_resp_data", o_resp_read_data, 64'd0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    chk("rstwr_mem_word", mem[8], 64'h0123456789ABCDEF);
    do_req(1'b0, 2'd3, 1'b0, 64'h40, 64'h0, 0, d, e, lat, rdc, wrc, bad);
    chk("rstwr_reload", d, 64'h0123456789ABCDEF);

    // Random traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      w  = 1'($urandom);
      sz = 2'($urandom);
      sg = 1'($urandom);
      wd = {$urandom, $urandom};
      r  = int'($urandom_range(0, 15));
      if (r == 0) begin
        a = 64'(512 + $urandom_range(0, 1000));
      end else if (r == 1) begin
        a = {$urandom, $urandom};
      end else begin
        a = 64'($urandom_range(0, 511));
        if (r > 3) a = a & ~((64'd1 << sz) - 64'd1);
      end
      model(w, sz, sg, a, wd, md, me, mlat);
      do_req(w, sz, sg, a, wd, int'($urandom_range(0, 2)), d, e, lat, rdc, wrc, bad);
      chk("rand_data", d, md);
      chk("rand_err", 64'(e), 64'(me));
      chk("rand_lat", 64'(lat), 64'(mlat));
      chk("rand_rd_cycle", 64'(rdc), 64'(exp_rd(mlat)));
      chk("rand_wr_cycle", 64'(wrc), 64'(exp_wr(mlat)));
      chk("rand_protocol", 64'(bad), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Request-side controller sitting directly upstream of the 64-entry doubleword data memory. Accepts one load or store per valid/ready handshake from the pipeline and checks size alignment and address range. Sequences the memory's read-then-write protocol (read captured at posedge, write committed at negedge), including read-modify-write for sub-doubleword stores. Returns a sign- or zero-extended load result or a store acknowledgement on a valid/ready response channel.

## Interface
- MEM_DEPTH, 64, number of 64-bit doublewords in the downstream memory; legal byte addresses are 0 .. 8*MEM_DEPTH-1
- Clock  in  1  single clock; all state updates on posedge
- Reset  in  1  asynchronous, active-high; returns block to IDLE immediately
- ReqValid  in  1  request present
- ReqReady  out  1  high only in IDLE
- ReqWrite  in  1  1=store, 0=load
- ReqSize  in  2  0=byte, 1=half, 2=word, 3=doubleword
- ReqSigned  in  1  loads only: 1=sign-extend, 0=zero-extend
- ReqAddress  in  64  byte address
- ReqWriteData  in  64  store data, right-justified (low bytes used)
- RespValid  out  1  response present; held until accepted
- RespReady  in  1  consumer accepts response
- RespReadData  out  64  extended load data; 0 for stores and errors
- RespError  out  1  misaligned or out-of-range request; no memory access made
- MemAddress  out  64  doubleword index = ReqAddress >> 3
- MemWriteData  out  64  full merged doubleword
- MemoryRead  out  1  read strobe to memory
- MemoryWrite  out  1  write strobe to memory
- MemReadData  in  64  memory read data, valid the cycle after a MemoryRead cycle

## Operation
- Accept on posedge with ReqValid && ReqReady; capture all Req* fields. Fields need not stay stable afterwards.
- Byte offset off = ReqAddress[2:0]; nbytes = 1 << ReqSize. Little-endian lanes: data occupies bits [8*off +: 8*nbytes].
- Error if off mod nbytes != 0, or if (ReqAddress >> 3) >= MEM_DEPTH. On error: go straight to RESP with RespError=1, RespReadData=0, no strobes.
- States:
  - IDLE -> RESP on error.
  - IDLE -> WR for a ReqSize=3 store.
  - IDLE -> RD for a load or a sub-doubleword store.
  - RD -> RDATA, unconditional.
  - RDATA -> RESP for a load. Extract the lane field, extend per ReqSigned, register it into RespReadData.
  - RDATA -> WR for a store. Merge the low nbytes of ReqWriteData into the lane; keep the other bytes of MemReadData.
  - WR -> RESP, unconditional.
  - RESP -> IDLE when RespReady.
- MemoryRead=1 only in RD. MemoryWrite=1 only in WR. The two are never both high.
- All memory outputs decode only from registered state and data, never from inputs, so they are stable well before negedge.
- MemAddress is held from RD through WR. MemWriteData is driven only in WR; otherwise 0.
- ReqSigned is ignored for ReqSize=3 and for stores.

## Timing
- Cycle k = k-th cycle after the accept edge. RespValid first high in:
  - error: cycle 1
  - doubleword store: cycle 2 (WR in cycle 1)
  - load: cycle 3 (RD in 1, RDATA in 2)
  - sub-doubleword store: cycle 4 (RD 1, RDATA 2, WR 3)
- The memory commits the store at the negedge inside the WR cycle.
- RespValid, RespReadData and RespError are held stable until the RespReady edge. The next request can be accepted no earlier than the cycle after that edge; RESP never bypasses to accept.
- Reset values: state IDLE, ReqReady=1, RespValid=0, RespError=0, RespReadData=0, MemAddress=0, MemWriteData=0, MemoryRead=0, MemoryWrite=0.
- Reset mid-operation aborts immediately; the response is lost. Reset during WR and before the negedge means no write occurs.
- ReqValid while busy is ignored (ReqReady=0) and is not queued.

## Test plan
- Doubleword store 0x1122334455667788 to address 0x10, then a doubleword load from 0x10 -> MemoryWrite high in cycle 1 with MemAddress=2; load RespReadData=0x1122334455667788 in cycle 3, RespError=0.
- Byte store 0xAB to address 0x13 over that data, then a doubleword load from 0x10 -> RD/RDATA/WR sequence, RespValid in cycle 4; reload returns 0x11223344AB667788.
- Signed byte load from 0x13 -> 0xFFFFFFFFFFFFFFAB. Unsigned -> 0x00000000000000AB. Signed half load from 0x12 -> 0xFFFFFFFFFFFFAB66.
- Word load from 0x06 (misaligned), and doubleword load from 0x200 with MEM_DEPTH=64 -> RespError=1 in cycle 1, RespReadData=0, MemoryRead and MemoryWrite never asserted.
- Hold RespReady=0 for 5 cycles after a load response -> RespValid and RespReadData stable, ReqReady=0 throughout; accept proceeds one cycle after RespReady is sampled high.
- Assert Reset during the WR cycle of a byte store, before the negedge -> MemoryWrite drops immediately, the memory word is unchanged, and all outputs take their reset values.
